// File: rtl/cpu_run_tracer_if.sv
// Load, RAM-write, core-control and trace-readback signals of cpu_run_tracer.
interface cpu_run_tracer_if #(
    parameter int unsigned W     = 32,
    parameter int unsigned NCH   = 5,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 9
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic              start;
    logic              ld_valid;
    logic [7:0]        ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_rst;
    logic              cpu_clk_en;
    logic [NCH*W-1:0]  trace_in;
    logic              rd_en;
    logic [NCH*W-1:0]  rd_data;
    logic              rd_valid;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              done;

    modport slave (
        input  start, ld_valid, ld_data, ld_last, trace_in, rd_en,
        output ld_ready, mem_we, mem_addr, mem_wdata, cpu_rst, cpu_clk_en,
        output rd_data, rd_valid, count, overflow, done
    );

    modport master (
        output start, ld_valid, ld_data, ld_last, trace_in, rd_en,
        input  ld_ready, mem_we, mem_addr, mem_wdata, cpu_rst, cpu_clk_en,
        input  rd_data, rd_valid, count, overflow, done
    );
endinterface

// File: rtl/cpu_run_tracer.sv
// Preload / reset / run / trace sequencer for the CU+datapath core.
// Optional TRACE_PC_FILTER_EN: in RUN only record samples whose PC changed.
module cpu_run_tracer #(
    parameter int unsigned W       = 32,
    parameter int unsigned NCH     = 5,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned AW      = 9,
    parameter int unsigned RST_CYC = 4,
    parameter int unsigned RUN_CYC = 200
) (
    input logic             Clk,
    input logic             Reset,
    cpu_run_tracer_if.slave bus
);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned TW  = NCH * W;
    localparam int unsigned SCW = $clog2((RUN_CYC > RST_CYC) ? RUN_CYC : RST_CYC) + 1;

    typedef enum logic [2:0] {StIdle, StLoad, StHold, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [SCW-1:0]   seq_q, seq_d;
    logic             ld_ready_q, ld_ready_d;
    logic             mem_we_q, mem_we_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [7:0]       mem_wdata_q, mem_wdata_d;
    logic             cpu_rst_q, cpu_rst_d;
    logic             cpu_clk_en_q, cpu_clk_en_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             rd_valid_q, rd_valid_d;
    logic [TW-1:0]    rd_data_q, rd_data_d;
    logic             done_q, done_d;
    logic [TW-1:0]    trace_mem [DEPTH];
    logic             wr_en;

`ifdef TRACE_PC_FILTER_EN
    logic             first_q, first_d;
    logic [W-1:0]     last_pc_q, last_pc_d;

    assign wr_en = cpu_clk_en_q && (first_q || (bus.trace_in[W-1:0] != last_pc_q));

    always_comb begin
        first_d   = (state_q != StRun) ? 1'b1 : (first_q & ~wr_en);
        last_pc_d = wr_en ? bus.trace_in[W-1:0] : last_pc_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            first_q   <= 1'b1;
            last_pc_q <= '0;
        end else begin
            first_q   <= first_d;
            last_pc_q <= last_pc_d;
        end
    end
`else
    assign wr_en = cpu_clk_en_q;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        seq_d        = seq_q;
        ld_ready_d   = ld_ready_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_rst_d    = cpu_rst_q;
        cpu_clk_en_d = cpu_clk_en_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        rd_valid_d   = 1'b0;
        rd_data_d    = rd_data_q;
        done_d       = done_q;

        // A full buffer drops its oldest entry so the newest samples survive.
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (count_q == CW'(DEPTH)) begin
                rd_ptr_d   = rd_ptr_q + PW'(1);
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d    = StLoad;
                    addr_d     = '0;
                    ld_ready_d = 1'b1;
                    cpu_rst_d  = 1'b1;
                    done_d     = 1'b0;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end else if (state_q == StDone && bus.rd_en && count_q != '0) begin
                    rd_data_d  = trace_mem[rd_ptr_q];
                    rd_valid_d = 1'b1;
                    rd_ptr_d   = rd_ptr_q + PW'(1);
                    count_d    = count_q - CW'(1);
                end
            end
            StLoad: begin
                if (bus.ld_valid && ld_ready_q) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = bus.ld_data;
                    addr_d      = addr_q + AW'(1);
                    // Top address ends the load so the image never wraps onto byte 0.
                    if (bus.ld_last || addr_q == '1) begin
                        state_d    = StHold;
                        ld_ready_d = 1'b0;
                        seq_d      = '0;
                    end
                end
            end
            StHold: begin
                if (seq_q == SCW'(RST_CYC - 1)) begin
                    state_d      = StRun;
                    seq_d        = '0;
                    cpu_rst_d    = 1'b0;
                    cpu_clk_en_d = 1'b1;
                end else begin
                    seq_d = seq_q + SCW'(1);
                end
            end
            StRun: begin
                if (seq_q == SCW'(RUN_CYC - 1)) begin
                    state_d      = StDone;
                    cpu_clk_en_d = 1'b0;
                    done_d       = 1'b1;
                end else begin
                    seq_d = seq_q + SCW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            seq_q        <= '0;
            ld_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_rst_q    <= 1'b1;
            cpu_clk_en_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            seq_q        <= seq_d;
            ld_ready_q   <= ld_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_rst_q    <= cpu_rst_d;
            cpu_clk_en_q <= cpu_clk_en_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            done_q       <= done_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en) trace_mem[wr_ptr_q] <= bus.trace_in;
    end

    assign bus.ld_ready   = ld_ready_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.cpu_rst    = cpu_rst_q;
    assign bus.cpu_clk_en = cpu_clk_en_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.done       = done_q;
endmodule
